// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer: 2-FF synchronisers, saturating stability counters, press/release strobes.
// Optional auto-repeat on held buttons is enabled by defining BTN_FILTER_REPEAT_EN.
module multi_btn_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic                clockSource,
  input  logic                resetN,
  input  logic [CHANNELS-1:0] rawButtons,
  output logic [CHANNELS-1:0] currentState,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic                anyPressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("multi_btn_debouncer: all parameters must be >= 1");
  end

  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_btn;
  logic [CHANNELS-1:0] state_nxt;
  logic [CHANNELS-1:0] repeat_fire;
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];

  assign btn_in = rawButtons ^ {CHANNELS{ACTIVE_LOW}};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt = currentState;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = '0;
      if (sync_btn[i] != currentState[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_nxt[i] = ~currentState[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clockSource or negedge resetN) begin
    if (!resetN) begin
      sync_meta    <= '0;
      sync_btn     <= '0;
      currentState <= '0;
      pressPulse   <= '0;
      releasePulse <= '0;
      anyPressed   <= 1'b0;
      // NOTE: the counter array is reset element by element; a stale count would shorten the first debounce.
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      sync_meta    <= btn_in;
      sync_btn     <= sync_meta;
      currentState <= state_nxt;
      pressPulse   <= (state_nxt & ~currentState) | repeat_fire;
      releasePulse <= ~state_nxt & currentState;
      anyPressed   <= |state_nxt;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

`ifdef BTN_FILTER_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_MAX);

  logic [HOLD_W-1:0]   hold_q   [CHANNELS];
  logic [HOLD_W-1:0]   hold_nxt [CHANNELS];
  logic [CHANNELS-1:0] rep_q;
  logic [CHANNELS-1:0] rep_nxt;

  // The first target is REPEAT_DELAY held cycles, later ones REPEAT_PERIOD; a release edge never fires.
  always_comb begin
    repeat_fire = '0;
    rep_nxt     = rep_q;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_nxt[i] = hold_q[i];
      if (!(currentState[i] && state_nxt[i])) begin
        hold_nxt[i] = '0;
        rep_nxt[i]  = 1'b0;
      end else if (hold_q[i] == (rep_q[i] ? HOLD_PERIOD : HOLD_DELAY)) begin
        repeat_fire[i] = 1'b1;
        hold_nxt[i]    = HOLD_W'(1);
        rep_nxt[i]     = 1'b1;
      end else if (hold_q[i] < HOLD_SAT) begin
        hold_nxt[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clockSource or negedge resetN) begin
    if (!resetN) begin
      rep_q <= '0;
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
    end else begin
      rep_q <= rep_nxt;
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= hold_nxt[i];
    end
  end
`else
  assign repeat_fire = '0;
`endif

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Self-checking bench for multi_btn_debouncer: directed scenarios plus random stimulus
// against a sliding-window reference model of the debounce rule.
module tb_multi_btn_debouncer;

  localparam int CH   = 4;
  localparam int DEB  = 8;
  localparam int RDLY = 16;
  localparam int RPER = 4;
  localparam int LAT  = DEB + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] raw;
  logic [CH-1:0] cur_state, press, rel;
  logic          any_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_btn_debouncer #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1'b0),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clockSource (clk),
    .resetN      (rst_n),
    .rawButtons  (raw),
    .currentState(cur_state),
    .pressPulse  (press),
    .releasePulse(rel),
    .anyPressed  (any_p)
  );

  // Reference model: a channel flips once the last DEB synchronised samples all disagree with it.
  logic [CH-1:0] raw_q  [$];
  logic [CH-1:0] seen_q [$];
  logic [CH-1:0] m_state, m_press, m_rel, m_nxt, m_seen;
  logic          m_any;
  bit            all_diff;
  int            age [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q.delete();
      seen_q.delete();
      repeat (2) raw_q.push_back('0);
      repeat (DEB) seen_q.push_back('0);
      m_state = '0;
      m_press = '0;
      m_rel   = '0;
      m_any   = 1'b0;
      for (int i = 0; i < CH; i++) age[i] = 0;
    end else begin
      m_seen = raw_q.pop_front();
      raw_q.push_back(raw);
      seen_q.push_back(m_seen);
      void'(seen_q.pop_front());
      m_nxt = m_state;
      for (int i = 0; i < CH; i++) begin
        all_diff = 1'b1;
        foreach (seen_q[k]) if (seen_q[k][i] == m_state[i]) all_diff = 1'b0;
        if (all_diff) m_nxt[i] = ~m_state[i];
      end
      m_press = m_nxt & ~m_state;
      m_rel   = ~m_nxt & m_state;
`ifdef BTN_FILTER_REPEAT_EN
      for (int i = 0; i < CH; i++) begin
        if (m_nxt[i] && m_state[i]) begin
          age[i]++;
          if (age[i] == RDLY + 1 || (age[i] > RDLY + 1 && (age[i] - RDLY - 1) % RPER == 0))
            m_press[i] = 1'b1;
        end else begin
          age[i] = 0;
        end
      end
`endif
      m_state = m_nxt;
      m_any   = |m_nxt;
    end
  end

  logic [3*CH:0] dut_v, mdl_v;
  assign dut_v = {cur_state, press, rel, any_p};
  assign mdl_v = {m_state, m_press, m_rel, m_any};

  task automatic tick(input logic [CH-1:0] v);
    raw = v;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3*CH:0] exp_v;
    rst_n = 1'b0;
    raw   = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_v !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", dut_v, 13'h0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick(4'hF);
      exp_v = {(k >= LAT) ? 4'hF : 4'h0, (k == LAT) ? 4'hF : 4'h0, 4'h0, k >= LAT};
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release edge=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp_b;
    for (int k = 0; k < LAT + 2; k++) tick(4'h0);
    for (int k = 1; k <= 20; k++) begin
      tick(4'h1);
      exp_b = {k >= LAT, k == LAT, 1'b0};
      checks++;
      if ({cur_state[0], press[0], rel[0]} !== exp_b || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL clean_press edge=%0d got=%h want=%b/%h", k, dut_v, exp_b, mdl_v);
      end
    end
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(4'h0);
      exp_b = {k < LAT, 1'b0, k == LAT};
      checks++;
      if ({cur_state[0], press[0], rel[0]} !== exp_b || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL clean_release edge=%0d got=%h want=%b/%h", k, dut_v, exp_b, mdl_v);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      tick(((k / 3) % 2 == 0) ? 4'h2 : 4'h0);
      checks++;
      if ({cur_state[1], press[1], rel[1]} !== 3'b000 || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL bounce_quiet cycle=%0d got=%h want=%h", k, dut_v, mdl_v);
      end
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      tick(4'h2);
      checks++;
      if ({cur_state[1], press[1]} !== {k >= LAT, k == LAT} || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL bounce_accept edge=%0d got=%h want=%h", k, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_threshold();
    int n_press, n_rel;
    for (int k = 0; k < LAT + 2; k++) tick(4'h4);
    for (int k = 1; k <= 7 + 12; k++) begin
      tick((k <= 7) ? 4'h0 : 4'h4);
      checks++;
      if ({cur_state[2], press[2], rel[2]} !== 3'b100 || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL glitch7 edge=%0d got=%h want=%h", k, dut_v, mdl_v);
      end
    end
    n_press = 0;
    n_rel   = 0;
    for (int k = 1; k <= 8 + 14; k++) begin
      tick((k <= 8) ? 4'h0 : 4'h4);
      n_press += press[2];
      n_rel   += rel[2];
      checks++;
      if ({cur_state[2], press[2], rel[2]} !== {!(k >= LAT && k < LAT + 8), k == LAT + 8, k == LAT}
          || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL glitch8 edge=%0d got=%h want=%h", k, dut_v, mdl_v);
      end
    end
    checks++;
    if (n_press != 1 || n_rel != 1) begin
      errors++;
      $display("FAIL glitch8_strobes got=%0d/%0d want=1/1", n_press, n_rel);
    end
  endtask

  task automatic test_reset_mid();
    logic [3*CH:0] exp_v;
    for (int k = 0; k < LAT + 2; k++) tick(4'h0);
    for (int k = 0; k < LAT + 2; k++) tick(4'h1);
    for (int k = 0; k < 7; k++) tick(4'h9);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear got=%h want=%h", dut_v, 13'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick(4'h9);
      exp_v = {(k >= LAT) ? 4'h9 : 4'h0, (k == LAT) ? 4'h9 : 4'h0, 4'h0, k >= LAT};
      checks++;
      if (dut_v !== exp_v || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL reset_mid_repress edge=%0d got=%h want=%h", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] v;
    int            len;
    for (int s = 0; s < 150; s++) begin
      v   = CH'($urandom_range(0, 15));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(LAT, 24) : $urandom_range(1, DEB);
      for (int k = 0; k < len; k++) begin
        tick(v);
        checks++;
        if (dut_v !== mdl_v) begin
          errors++;
          $display("FAIL random seg=%0d got=%h want=%h", s, dut_v, mdl_v);
        end
      end
    end
  endtask

`ifdef BTN_FILTER_REPEAT_EN
  task automatic test_repeat();
    logic exp_p;
    for (int k = 0; k < LAT + 2; k++) tick(4'h0);
    for (int k = 1; k <= 40; k++) begin
      tick(4'h1);
      exp_p = (k == LAT) || (k == LAT + RDLY + 1) ||
              (k > LAT + RDLY + 1 && (k - LAT - RDLY - 1) % RPER == 0);
      checks++;
      if (press[0] !== exp_p || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL repeat_hold edge=%0d got=%b want=%b", k, press[0], exp_p);
      end
    end
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(4'h0);
      checks++;
      if (press[0] !== 1'b0 || rel[0] !== (k == LAT) || dut_v !== mdl_v) begin
        errors++;
        $display("FAIL repeat_release edge=%0d got=%h want=%h", k, dut_v, mdl_v);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_threshold();
    test_reset_mid();
`ifdef BTN_FILTER_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
